// File: rtl/param_cpu_pkg.sv
// Shared types for the param_mem_cpu accumulator-less memory CPU:
// opcode encoding, run/halt state and the sign/zero/carry flag bundle.
package param_cpu_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'h0,
        OpSub  = 4'h1,
        OpXchg = 4'h2,
        OpMov  = 4'h3,
        OpShr  = 4'h4,
        OpIn   = 4'h5,
        OpOut  = 4'h6,
        OpAnd  = 4'h7,
        OpClrf = 4'h8,
        OpOr   = 4'h9,
        OpXor  = 4'hA,
        OpPush = 4'hB,
        OpPop  = 4'hC,
        OpShl  = 4'hD,
        OpNot  = 4'hE,
        OpHlt  = 4'hF
    } opcode_e;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_e;

    typedef struct packed {
        logic s;
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/param_mem_cpu_if.sv
// Instruction/result bus of param_mem_cpu. The slave modport is the CPU side,
// the master modport is the side that issues instructions.
interface param_mem_cpu_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] din;
    logic              resume;
    logic              out_valid;
    logic [DATA_W-1:0] dout;
    logic              hlt;
    logic              s_flag;
    logic              z_flag;
    logic              c_flag;
    logic              stk_err;

    modport master (
        output in_valid, opcode, address, din, resume,
        input  in_ready, out_valid, dout, hlt, s_flag, z_flag, c_flag, stk_err
    );

    modport slave (
        input  in_valid, opcode, address, din, resume,
        output in_ready, out_valid, dout, hlt, s_flag, z_flag, c_flag, stk_err
    );
endinterface

// File: rtl/param_cpu_stack.sv
// LIFO for PUSH/POP. Push when full and pop when empty are ignored here;
// the CPU reports them through its sticky error flag.
module param_cpu_stack #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned STACK_DEPTH = 8,
    localparam int unsigned SpW        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [SpW-1:0]    o_sp,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int unsigned IdxW = $clog2(STACK_DEPTH);

    logic [DATA_W-1:0] r_mem [STACK_DEPTH];
    logic [SpW-1:0]    r_sp;
    logic [IdxW-1:0]   w_wr_idx;
    logic [IdxW-1:0]   w_rd_idx;

    assign w_wr_idx = IdxW'(r_sp);
    assign w_rd_idx = IdxW'(r_sp - 1'b1);
    assign o_full   = (r_sp == SpW'(STACK_DEPTH));
    assign o_empty  = (r_sp == '0);
    assign o_sp     = r_sp;
    assign o_rdata  = o_empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sp <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                r_mem[IdxW'(i)] <= '0;
            end
        end else if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_wdata;
            r_sp            <= r_sp + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - 1'b1;
        end
    end
endmodule

// File: rtl/param_mem_cpu.sv
// Memory-operand CPU: one instruction per cycle in RUN, results registered one cycle later.
// Optional PARAM_CPU_ROTATE_EN turns SHR/SHL into rotates.
module param_mem_cpu #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    param_mem_cpu_if.slave bus
);
    import param_cpu_pkg::*;

    localparam int unsigned MemDepth = 2 ** ADDR_W;
    localparam int unsigned SpW      = $clog2(STACK_DEPTH + 1);
`ifdef PARAM_CPU_ROTATE_EN
    localparam logic RotEn = 1'b1;
`else
    localparam logic RotEn = 1'b0;
`endif

    state_e            r_state;
    state_e            w_state_next;
    logic [DATA_W-1:0] r_mem [MemDepth];
    logic [DATA_W-1:0] r_dout;
    flags_t            r_flags;
    logic              r_stk_err;
    logic              r_out_valid;

    opcode_e           w_op;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [DATA_W-1:0] w_m;
    logic [DATA_W-1:0] w_m_nx;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_wr;
    logic              w_wr2;
    logic              w_upd_dout;
    logic              w_set_flags;
    logic              w_clr;
    logic              w_err_set;
    logic              w_push;
    logic              w_pop;
    logic              w_stk_push;
    logic              w_stk_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_top;
    logic [SpW-1:0]    w_sp_unused;

    assign w_op      = opcode_e'(bus.opcode);
    assign w_accept  = bus.in_valid && (r_state == StRun);
    assign w_addr_nx = bus.address + 1'b1;
    assign w_m       = r_mem[bus.address];
    assign w_m_nx    = r_mem[w_addr_nx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRun:  if (w_accept && (w_op == OpHlt)) w_state_next = StHalt;
            StHalt: if (bus.resume) w_state_next = StRun;
        endcase
    end

    always_comb begin
        w_res       = w_m;
        w_c         = 1'b0;
        w_wr        = 1'b0;
        w_wr2       = 1'b0;
        w_upd_dout  = 1'b1;
        w_set_flags = 1'b1;
        w_clr       = 1'b0;
        w_err_set   = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        unique case (w_op)
            OpAdd: begin
                {w_c, w_res} = {1'b0, w_m} + {1'b0, bus.din};
                w_wr         = 1'b1;
            end
            OpSub: begin
                w_res = w_m - bus.din;
                w_c   = (w_m < bus.din);
                w_wr  = 1'b1;
            end
            OpXchg: begin
                w_res = w_m_nx;
                w_wr  = 1'b1;
                w_wr2 = 1'b1;
            end
            OpMov: begin
                w_res = r_mem[0];
                w_wr  = 1'b1;
            end
            OpShr: begin
                w_c   = w_m[0];
                w_res = {RotEn & w_m[0], w_m[DATA_W-1:1]};
                w_wr  = 1'b1;
            end
            OpIn: begin
                w_res = bus.din;
                w_wr  = 1'b1;
            end
            OpOut: ;
            OpAnd: begin
                w_res = w_m & bus.din;
                w_wr  = 1'b1;
            end
            OpClrf: begin
                w_set_flags = 1'b0;
                w_clr       = 1'b1;
            end
            OpOr: begin
                w_res = w_m | bus.din;
                w_wr  = 1'b1;
            end
            OpXor: begin
                w_res = w_m ^ bus.din;
                w_wr  = 1'b1;
            end
            OpPush: begin
                w_push    = !w_full;
                w_err_set = w_full;
            end
            OpPop: begin
                // Empty pop reports M and leaves memory alone.
                if (w_empty) begin
                    w_err_set = 1'b1;
                end else begin
                    w_pop = 1'b1;
                    w_res = w_top;
                    w_wr  = 1'b1;
                end
            end
            OpShl: begin
                w_c   = w_m[DATA_W-1];
                w_res = {w_m[DATA_W-2:0], RotEn & w_m[DATA_W-1]};
                w_wr  = 1'b1;
            end
            OpNot: begin
                w_res = ~w_m;
                w_wr  = 1'b1;
            end
            OpHlt: begin
                w_upd_dout  = 1'b0;
                w_set_flags = 1'b0;
            end
        endcase
    end

    assign w_stk_push = w_accept && w_push;
    assign w_stk_pop  = w_accept && w_pop;

    param_cpu_stack #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_stk_push),
        .i_pop   (w_stk_pop),
        .i_wdata (w_m),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_sp    (w_sp_unused),
        .o_rdata (w_top)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MemDepth; i++) begin
                r_mem[ADDR_W'(i)] <= DATA_W'(i);
            end
        end else if (w_accept) begin
            if (w_wr) r_mem[bus.address] <= w_res;
            if (w_wr2) r_mem[w_addr_nx] <= w_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_flags     <= '0;
            r_stk_err   <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                if (w_upd_dout) r_dout <= w_res;
                if (w_clr) begin
                    r_flags   <= '0;
                    r_stk_err <= 1'b0;
                end else begin
                    if (w_set_flags) begin
                        r_flags <= '{s: w_res[DATA_W-1], z: (w_res == '0), c: w_c};
                    end
                    if (w_err_set) r_stk_err <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == StRun);
    assign bus.hlt       = (r_state == StHalt);
    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
    assign bus.s_flag    = r_flags.s;
    assign bus.z_flag    = r_flags.z;
    assign bus.c_flag    = r_flags.c;
    assign bus.stk_err   = r_stk_err;
endmodule
